moesi_req_arbiter: RTL and testbench
====================================

Name: moesi_req_arbiter

Overview:
- Front end of the distributed MOESI directory.
- Collects read/write requests from three processors into per-processor FIFOs.
- Picks one request per cycle using round-robin.
- Drives the directory's single-request interface (req_proc, read_req, write_req) with registered outputs, so the directory never sees two requests in one cycle.

Parameters:
- FIFO_DEPTH, 4, entries per processor FIFO; power of two, minimum 2.
- PTR_W, 2, log2(FIFO_DEPTH); must match FIFO_DEPTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cpu_valid  input  3  bit i = processor i presents a request.
- cpu_wr  input  3  bit i = 1 for write, 0 for read; qualified by cpu_valid[i].
- cpu_ready  output  3  bit i = FIFO i can accept; combinational, equals !full_i.
- dir_stall  input  1  1 = directory must receive no request this cycle.
- req_proc  output  2  processor ID of the issued request (0..2); registered.
- read_req  output  1  registered pulse: issued request is a read.
- write_req  output  1  registered pulse: issued request is a write.
- issue_ack  output  3  registered one-hot pulse: the processor whose request was issued.

Behaviour:
- Reset (async, active-high):
  - All FIFOs empty; count_i = 0.
  - rr_ptr = 0.
  - req_proc = 0, read_req = 0, write_req = 0, issue_ack = 0.
  - cpu_ready = 3'b111 while reset is asserted and after release.
- FIFO i:
  - 1-bit entries (the op).
  - Write pointer, read pointer and a count of width PTR_W+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - full_i = (count_i == FIFO_DEPTH); empty_i = (count_i == 0).
- Enqueue: on posedge, if cpu_valid[i] && cpu_ready[i], push cpu_wr[i].
  - No push when full, even if a pop happens the same cycle.
  - cpu_ready depends only on registered count, never on the pop decision.
- No bypass: an entry pushed at edge N can first be selected at edge N+1.
  - Best-case latency from the accepting edge to read_req/write_req high is one cycle.
- Selection, evaluated every cycle:
  - If dir_stall == 0 and any FIFO is non-empty, scan the FIFOs in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first non-empty FIFO j wins.
  - On posedge: pop FIFO j; req_proc <= j; read_req <= !head_j; write_req <= head_j; issue_ack <= (1<<j); rr_ptr <= (j+1) mod 3.
- Idle cycle (dir_stall == 1 or all FIFOs empty):
  - read_req <= 0, write_req <= 0, issue_ack <= 0.
  - req_proc holds its last value; rr_ptr unchanged.
  - FIFOs still accept pushes during stall.
- Push and pop on the same FIFO in the same cycle: count unchanged, both pointers advance.
- Invariant: read_req and write_req are never both 1, and never 1 without exactly one issue_ack bit set.
- Processor index 3 never appears on req_proc.
- rr_ptr takes values 0..2 only; value 3 is unreachable.
  - If rr_ptr is ever 3, treat it as 0.
- Reset mid-operation: all queued requests are discarded and outputs clear immediately, without waiting for clk.
  - After release, the first issue can occur one edge after the first new push.
- Throughput: one request per cycle sustained when at least one FIFO is non-empty and dir_stall == 0.

Test Plan:
- Single read:
  - Stimulus: reset; then cpu_valid = 3'b010, cpu_wr = 0 for one cycle.
  - Required: the following cycle shows req_proc = 1, read_req = 1, write_req = 0, issue_ack = 3'b010, each high for exactly one cycle.
- Round-robin fairness:
  - Stimulus: push one write into each of FIFOs 0, 1, 2 in the same cycle.
  - Required: three consecutive issues with req_proc 0, 1, 2, write_req = 1 each.
  - Then push P0 read and P2 read together: issue order is P0 then P2 (rr_ptr = 0 after the P2 grant).
- Full/backpressure:
  - Stimulus: dir_stall = 1; hold cpu_valid[0] = 1 for 6 cycles.
  - Required: cpu_ready[0] drops to 0 after 4 accepts; exactly 4 entries are queued.
  - Release stall: 4 issues from P0 on consecutive cycles in push order (op pattern preserved); cpu_ready[0] returns to 1 after the first pop.
- Stall mid-stream:
  - Stimulus: assert dir_stall for 3 cycles while P1 has 2 queued reads.
  - Required: no read_req/write_req/issue_ack during the stall; both reads issue afterwards; req_proc holds 1 throughout.
- Async reset mid-operation:
  - Stimulus: assert reset between edges while read_req = 1 and FIFOs hold entries.
  - Required: read_req, write_req, issue_ack drop immediately; cpu_ready = 3'b111; no stale request issues after release.
- Simultaneous push/pop:
  - Stimulus: FIFO 2 holds 1 entry; push a new entry in the same cycle that entry issues.
  - Required: count stays 1; the new entry issues on the next cycle.

Source files
------------

// File: rtl/moesi_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// moesi_req_arbiter_if
// Groups the processor-side handshake and the directory-side request bus of
// the MOESI request arbiter into one bundle.
//
// Signals:
//   cpu_valid [2:0]  processor i presents a request
//   cpu_wr    [2:0]  processor i request is a write (1) or read (0)
//   cpu_ready [2:0]  FIFO i can accept a request this cycle
//   dir_stall        directory refuses a request this cycle
//   req_proc  [1:0]  processor ID of the issued request
//   read_req         one-cycle pulse: issued request is a read
//   write_req        one-cycle pulse: issued request is a write
//   issue_ack [2:0]  one-hot pulse naming the processor that was issued
//
// Modports:
//   slave  - the arbiter itself
//   master - the processors/directory side (or a testbench standing in)
// ---------------------------------------------------------------------------
interface moesi_req_arbiter_if;
    logic [2:0] cpu_valid;
    logic [2:0] cpu_wr;
    logic [2:0] cpu_ready;
    logic       dir_stall;
    logic [1:0] req_proc;
    logic       read_req;
    logic       write_req;
    logic [2:0] issue_ack;

    modport slave (
        input  cpu_valid,
        input  cpu_wr,
        input  dir_stall,
        output cpu_ready,
        output req_proc,
        output read_req,
        output write_req,
        output issue_ack
    );

    modport master (
        output cpu_valid,
        output cpu_wr,
        output dir_stall,
        input  cpu_ready,
        input  req_proc,
        input  read_req,
        input  write_req,
        input  issue_ack
    );
endinterface

// File: rtl/moesi_req_arbiter.sv
// ---------------------------------------------------------------------------
// moesi_req_arbiter
// Front end of the distributed MOESI directory. Each of three processors
// pushes read/write requests into its own small FIFO; every cycle one
// non-empty FIFO is chosen round-robin and its head request is presented to
// the directory on registered outputs, so the directory sees at most one
// request per cycle.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous, active-high; discards all queued requests
//   bus    - moesi_req_arbiter_if.slave: processor handshake
//            (cpu_valid/cpu_wr/cpu_ready) and directory request bus
//            (dir_stall/req_proc/read_req/write_req/issue_ack)
//
// Parameters:
//   FIFO_DEPTH - entries per processor FIFO (power of two, >= 2)
//   PTR_W      - log2(FIFO_DEPTH)
// ---------------------------------------------------------------------------
module moesi_req_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    moesi_req_arbiter_if.slave bus
);

    localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [2:0] w_full;
    logic [2:0] w_empty;
    logic [2:0] w_push;
    logic [2:0] w_pop;
    logic [2:0] w_head;

    logic       w_grantValid;
    logic [1:0] w_grantIdx;
    logic [1:0] w_order [3];

    logic [1:0] r_rrPtr;
    logic [1:0] r_reqProc;
    logic       r_readReq;
    logic       r_writeReq;
    logic [2:0] r_issueAck;

    // Ready comes only from the registered count, so a FIFO that is full
    // refuses a push even in a cycle where it is also being popped.
    assign bus.cpu_ready = ~w_full;
    assign w_push        = bus.cpu_valid & ~w_full;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fifo
            logic [FIFO_DEPTH-1:0] r_mem;
            logic [PTR_W-1:0]      r_wrPtr;
            logic [PTR_W-1:0]      r_rdPtr;
            logic [PTR_W:0]        r_count;

            assign w_full[gi]  = (r_count == DEPTH_COUNT);
            assign w_empty[gi] = (r_count == '0);
            assign w_head[gi]  = r_mem[r_rdPtr];
            assign w_pop[gi]   = w_grantValid && (w_grantIdx == 2'(gi));

            // Per-processor op FIFO. Each entry is just the write flag.
            // Pointers wrap naturally at FIFO_DEPTH; a simultaneous push and
            // pop moves both pointers and leaves the count alone.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mem   <= '0;
                    r_wrPtr <= '0;
                    r_rdPtr <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_mem[r_wrPtr] <= bus.cpu_wr[gi];
                        r_wrPtr        <= r_wrPtr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rdPtr <= r_rdPtr + 1'b1;
                    end
                    if (w_push[gi] && !w_pop[gi]) begin
                        r_count <= r_count + 1'b1;
                    end else if (!w_push[gi] && w_pop[gi]) begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Scan order starting at the round-robin pointer. A pointer value of 3
    // cannot be reached, but if it ever were it behaves like 0.
    always_comb begin
        w_order[0] = 2'd0;
        w_order[1] = 2'd1;
        w_order[2] = 2'd2;
        case (r_rrPtr)
            2'd1: begin
                w_order[0] = 2'd1;
                w_order[1] = 2'd2;
                w_order[2] = 2'd0;
            end
            2'd2: begin
                w_order[0] = 2'd2;
                w_order[1] = 2'd0;
                w_order[2] = 2'd1;
            end
            default: begin
                w_order[0] = 2'd0;
                w_order[1] = 2'd1;
                w_order[2] = 2'd2;
            end
        endcase
    end

    // Grant selection. Walking the scan order backwards lets the earliest
    // non-empty FIFO in round-robin order overwrite any later candidate.
    // Only registered FIFO state is looked at, so a request pushed on this
    // edge cannot be granted before the next one.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = 2'd0;
        if (!bus.dir_stall) begin
            for (int k = 2; k >= 0; k--) begin
                if (!w_empty[w_order[k]]) begin
                    w_grantValid = 1'b1;
                    w_grantIdx   = w_order[k];
                end
            end
        end
    end

    // Registered directory request. Pulses clear on any idle cycle while
    // req_proc keeps naming the last processor issued. The pointer moves
    // to the processor just after the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr    <= 2'd0;
            r_reqProc  <= 2'd0;
            r_readReq  <= 1'b0;
            r_writeReq <= 1'b0;
            r_issueAck <= 3'b000;
        end else if (w_grantValid) begin
            r_reqProc  <= w_grantIdx;
            r_readReq  <= ~w_head[w_grantIdx];
            r_writeReq <= w_head[w_grantIdx];
            r_issueAck <= 3'b001 << w_grantIdx;
            r_rrPtr    <= (w_grantIdx == 2'd2) ? 2'd0 : w_grantIdx + 2'd1;
        end else begin
            r_readReq  <= 1'b0;
            r_writeReq <= 1'b0;
            r_issueAck <= 3'b000;
        end
    end

    assign bus.req_proc  = r_reqProc;
    assign bus.read_req  = r_readReq;
    assign bus.write_req = r_writeReq;
    assign bus.issue_ack = r_issueAck;

endmodule

// File: tb/tb_moesi_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_moesi_req_arbiter
// Directed testbench for moesi_req_arbiter: a vector table for single-cycle
// behaviour followed by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_moesi_req_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    moesi_req_arbiter_if arbBus();

    moesi_req_arbiter #(
        .FIFO_DEPTH(4),
        .PTR_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(arbBus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] valid;
        logic [2:0] wr;
        logic       stall;
        logic [1:0] expProc;
        logic       expRead;
        logic       expWrite;
        logic [2:0] expAck;
        logic [2:0] expReady;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] fullPat;

    // Single scalar comparison.
    task automatic checkVal(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Compares the whole directory bus plus cpu_ready as one check.
    task automatic checkOutput(input string name, input logic [1:0] p, input logic r,
                               input logic w, input logic [2:0] a, input logic [2:0] rdy);
        total++;
        if (arbBus.req_proc !== p || arbBus.read_req !== r || arbBus.write_req !== w ||
            arbBus.issue_ack !== a || arbBus.cpu_ready !== rdy) begin
            bad++;
            $display("[TB] FAIL %s: got proc=%0d rd=%b wr=%b ack=%b ready=%b expected proc=%0d rd=%b wr=%b ack=%b ready=%b",
                     name, arbBus.req_proc, arbBus.read_req, arbBus.write_req, arbBus.issue_ack,
                     arbBus.cpu_ready, p, r, w, a, rdy);
        end
    endtask

    // Drive inputs just after an edge, then move to 1ns past the next edge.
    task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] wr, input logic stall);
        arbBus.cpu_valid = valid;
        arbBus.cpu_wr    = wr;
        arbBus.dir_stall = stall;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(3'b000, 3'b000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        arbBus.cpu_valid = 3'b000;
        arbBus.cpu_wr    = 3'b000;
        arbBus.dir_stall = 1'b0;

        // rst, valid, wr, stall, expProc, expRead, expWrite, expAck, expReady
        vecs.push_back(vec_t'{1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 3'b111});
        // single read from P1
        vecs.push_back(vec_t'{1'b0, 3'b010, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b010, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000, 3'b111});
        // fresh reset, then one write into every FIFO
        vecs.push_back(vec_t'{1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b111, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, 3'b001, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0, 1'b1, 3'b010, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0, 1'b1, 3'b100, 3'b111});
        // P0 and P2 reads together: P0 first, then P2
        vecs.push_back(vec_t'{1'b0, 3'b101, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 3'b001, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, 3'b100, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000, 3'b111});
        // P2 write queued, then a read pushed the same cycle the write issues
        vecs.push_back(vec_t'{1'b0, 3'b100, 3'b100, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b100, 3'b000, 1'b0, 2'd2, 1'b0, 1'b1, 3'b100, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 1'b1, 1'b0, 3'b100, 3'b111});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000, 3'b111});

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            applyStimulus(vecs[i].valid, vecs[i].wr, vecs[i].stall);
            checkOutput($sformatf("vec%0d", i), vecs[i].expProc, vecs[i].expRead,
                        vecs[i].expWrite, vecs[i].expAck, vecs[i].expReady);
        end
        reset = 1'b0;

        // Full/backpressure: six pushes offered to P0 under stall, four land.
        doReset();
        fullPat = 6'b001101;
        for (int c = 0; c < 6; c++) begin
            checkVal($sformatf("fullReadyPre%0d", c), {7'd0, arbBus.cpu_ready[0]}, (c < 4) ? 8'd1 : 8'd0);
            applyStimulus(3'b001, {2'b00, fullPat[c]}, 1'b1);
            checkOutput($sformatf("fullStall%0d", c), 2'd0, 1'b0, 1'b0, 3'b000,
                        (c < 3) ? 3'b111 : 3'b110);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b000, 3'b000, 1'b0);
            checkOutput($sformatf("fullDrain%0d", k), 2'd0, ~fullPat[k], fullPat[k], 3'b001, 3'b111);
        end
        applyStimulus(3'b000, 3'b000, 1'b0);
        checkOutput("fullEmpty", 2'd0, 1'b0, 1'b0, 3'b000, 3'b111);

        // Stall mid-stream with two reads queued on P1.
        doReset();
        applyStimulus(3'b010, 3'b000, 1'b0);
        checkOutput("stallPush", 2'd0, 1'b0, 1'b0, 3'b000, 3'b111);
        applyStimulus(3'b000, 3'b000, 1'b0);
        checkOutput("stallFirst", 2'd1, 1'b1, 1'b0, 3'b010, 3'b111);
        for (int s = 0; s < 5; s++) begin
            applyStimulus((s < 2) ? 3'b010 : 3'b000, 3'b000, 1'b1);
            checkOutput($sformatf("stallHold%0d", s), 2'd1, 1'b0, 1'b0, 3'b000, 3'b111);
        end
        for (int s = 0; s < 2; s++) begin
            applyStimulus(3'b000, 3'b000, 1'b0);
            checkOutput($sformatf("stallDrain%0d", s), 2'd1, 1'b1, 1'b0, 3'b010, 3'b111);
        end
        applyStimulus(3'b000, 3'b000, 1'b0);
        checkOutput("stallIdle", 2'd1, 1'b0, 1'b0, 3'b000, 3'b111);

        // Asynchronous reset while a read is on the bus and FIFOs are loaded.
        doReset();
        applyStimulus(3'b111, 3'b000, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0);
        checkOutput("arstBefore", 2'd0, 1'b1, 1'b0, 3'b001, 3'b111);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arstImmediate", 2'd0, 1'b0, 1'b0, 3'b000, 3'b111);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(3'b000, 3'b000, 1'b0);
            checkOutput($sformatf("arstNoStale%0d", s), 2'd0, 1'b0, 1'b0, 3'b000, 3'b111);
        end
        applyStimulus(3'b100, 3'b100, 1'b0);
        checkOutput("arstNewPush", 2'd0, 1'b0, 1'b0, 3'b000, 3'b111);
        applyStimulus(3'b000, 3'b000, 1'b0);
        checkOutput("arstNewIssue", 2'd2, 1'b0, 1'b1, 3'b100, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
